// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM stage: control-bus bit positions, FSM states
// and the access-size decode used by both the top and the lane aligner.
package mem_access_unit_pkg;

    localparam int unsigned SB_BIT       = 8;
    localparam int unsigned SH_BIT       = 7;
    localparam int unsigned LB_BIT       = 6;
    localparam int unsigned LH_BIT       = 5;
    localparam int unsigned UNSIGNED_BIT = 4;
    localparam int unsigned BNEQ_BIT     = 3;
    localparam int unsigned BRANCH_BIT   = 2;
    localparam int unsigned MEMREAD_BIT  = 1;
    localparam int unsigned MEMWRITE_BIT = 0;

    localparam int unsigned REGWRITE_BIT = 1;
    localparam int unsigned MEMTOREG_BIT = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // A write wins when MemRead and MemWrite are both set, so the store size bits apply.
    function automatic size_e access_size(input logic [8:0] ctrl);
        size_e sz;
        sz = SZ_WORD;
        if (ctrl[MEMWRITE_BIT]) begin
            if (ctrl[SB_BIT])      sz = SZ_BYTE;
            else if (ctrl[SH_BIT]) sz = SZ_HALF;
        end else begin
            if (ctrl[LB_BIT])      sz = SZ_BYTE;
            else if (ctrl[LH_BIT]) sz = SZ_HALF;
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load
// lane extraction with sign or zero extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        be_o     = 4'b1111;
        wdata_o  = store_data_i;
        load_o   = rdata_i;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_i;
                wdata_o = {4{store_data_i[7:0]}};
                load_o  = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
            end
            SZ_HALF: begin
                be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{store_data_i[15:0]}};
                load_o  = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage executor: branch resolution, req/ready data-memory access, load extension.
// Optional MEM_ACCESS_MISALIGN_TRAP_EN: misaligned half/word accesses are trapped, not issued.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int NB_DATA    = 32,
    parameter int NB_CTRL_M  = 9,
    parameter int NB_CTRL_WB = 2,
    parameter int NB_REG     = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
    input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
    input  logic [NB_DATA-1:0]    i_alu_result,
    input  logic                  i_zero,
    input  logic [NB_DATA-1:0]    i_store_data,
    input  logic [NB_REG-1:0]     i_rd_addr,
    output logic                  o_stall,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [NB_DATA-1:0]    o_mem_addr,
    output logic [3:0]            o_mem_be,
    output logic [NB_DATA-1:0]    o_mem_wdata,
    input  logic                  i_mem_ready,
    input  logic [NB_DATA-1:0]    i_mem_rdata,
    output logic                  o_valid,
    output logic [NB_DATA-1:0]    o_load_data,
    output logic [NB_DATA-1:0]    o_alu_result,
    output logic [NB_REG-1:0]     o_rd_addr,
    output logic [NB_CTRL_WB-1:0] o_ctrl_wb_bus,
    output logic                  o_pc_src,
    output logic                  o_misaligned
);

    state_e                state_q;
    logic [NB_DATA-1:0]    addr_q, store_q;
    size_e                 size_q;
    logic                  unsigned_q, we_q;
    logic [NB_REG-1:0]     rd_q;
    logic [NB_CTRL_WB-1:0] wb_q;

    logic                  valid_q, pc_src_q, mis_q;
    logic [NB_DATA-1:0]    load_q, alu_q;
    logic [NB_REG-1:0]     rd_out_q;
    logic [NB_CTRL_WB-1:0] wb_out_q;

    logic                  memop, misalign, req;
    size_e                 size_in;
    logic [3:0]            lane_be;
    logic [NB_DATA-1:0]    lane_wdata, lane_load;

    assign memop   = i_ctrl_mem_bus[MEMREAD_BIT] | i_ctrl_mem_bus[MEMWRITE_BIT];
    assign size_in = access_size(i_ctrl_mem_bus);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign misalign = ((size_in == SZ_HALF) && i_alu_result[0]) ||
                      ((size_in == SZ_WORD) && (i_alu_result[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    mem_lane_align u_lane (
        .addr_i       (addr_q[1:0]),
        .size_i       (size_q),
        .unsigned_i   (unsigned_q),
        .store_data_i (store_q),
        .rdata_i      (i_mem_rdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .load_o       (lane_load)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            store_q    <= '0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            we_q       <= 1'b0;
            rd_q       <= '0;
            wb_q       <= '0;
            valid_q    <= 1'b0;
            pc_src_q   <= 1'b0;
            mis_q      <= 1'b0;
            load_q     <= '0;
            alu_q      <= '0;
            rd_out_q   <= '0;
            wb_out_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!i_valid) begin
                        valid_q <= 1'b0;
                    end else if (memop && !misalign) begin
                        state_q    <= ST_REQ;
                        addr_q     <= i_alu_result;
                        store_q    <= i_store_data;
                        size_q     <= size_in;
                        unsigned_q <= i_ctrl_mem_bus[UNSIGNED_BIT];
                        we_q       <= i_ctrl_mem_bus[MEMWRITE_BIT];
                        rd_q       <= i_rd_addr;
                        wb_q       <= i_ctrl_wb_bus;
                        valid_q    <= 1'b0;
                    end else begin
                        // Non-memory ops and trapped accesses both retire in one cycle.
                        valid_q  <= 1'b1;
                        mis_q    <= memop;
                        pc_src_q <= !memop && i_ctrl_mem_bus[BRANCH_BIT] &&
                                    (i_ctrl_mem_bus[BNEQ_BIT] ? !i_zero : i_zero);
                        load_q   <= '0;
                        alu_q    <= i_alu_result;
                        rd_out_q <= i_rd_addr;
                        wb_out_q <= memop ? '0 : i_ctrl_wb_bus;
                    end
                end
                ST_REQ: begin
                    if (i_mem_ready) begin
                        state_q  <= ST_IDLE;
                        valid_q  <= 1'b1;
                        mis_q    <= 1'b0;
                        pc_src_q <= 1'b0;
                        load_q   <= we_q ? '0 : lane_load;
                        alu_q    <= addr_q;
                        rd_out_q <= rd_q;
                        wb_out_q <= wb_q;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req           = (state_q == ST_REQ);
    assign o_stall       = ((state_q == ST_IDLE) && i_valid && memop && !misalign) ||
                           (req && !i_mem_ready);
    assign o_mem_req     = req;
    assign o_mem_we      = req & we_q;
    assign o_mem_addr    = req ? {addr_q[NB_DATA-1:2], 2'b00} : '0;
    assign o_mem_be      = req ? lane_be : '0;
    assign o_mem_wdata   = req ? lane_wdata : '0;
    assign o_valid       = valid_q;
    assign o_load_data   = load_q;
    assign o_alu_result  = alu_q;
    assign o_rd_addr     = rd_out_q;
    assign o_ctrl_wb_bus = wb_out_q;
    assign o_pc_src      = pc_src_q;
    assign o_misaligned  = mis_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage executor for the MIPS pipeline. It consumes the EX/MEM memory and writeback control buses produced by instruction decode, resolves BEQ/BNE, and runs byte, halfword and word loads and stores against a data memory over a req/ready handshake. It also sign- or zero-extends load data and presents registered results to the MEM/WB stage. It stalls the upstream pipeline while a memory transaction is outstanding.

## Interface
- NB_DATA, 32, data and address width
- NB_CTRL_M, 9, memory control bus width
- NB_CTRL_WB, 2, writeback control bus width
- NB_REG, 5, register index width
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, synchronous, active-low
- i_valid  in  1  EX/MEM holds a valid instruction
- i_ctrl_mem_bus  in  NB_CTRL_M  [8]SB [7]SH [6]LB [5]LH [4]Unsigned [3]BNEQ [2]Branch [1]MemRead [0]MemWrite
- i_ctrl_wb_bus  in  NB_CTRL_WB  [1]RegWrite [0]MemtoReg
- i_alu_result  in  NB_DATA  ALU result / effective byte address
- i_zero  in  1  ALU zero flag
- i_store_data  in  NB_DATA  rt value for stores
- i_rd_addr  in  NB_REG  destination register
- o_stall  out  1  upstream must hold EX/MEM (combinational)
- o_mem_req  out  1  memory request
- o_mem_we  out  1  write request
- o_mem_addr  out  NB_DATA  word-aligned address ({addr[31:2],2'b00})
- o_mem_be  out  4  byte enables, bit0 = addr byte 0 (little-endian)
- o_mem_wdata  out  NB_DATA  lane-replicated store data
- i_mem_ready  in  1  memory accepts / completes the request this cycle
- i_mem_rdata  in  NB_DATA  read word, valid when i_mem_ready on a read
- o_valid  out  1  MEM/WB outputs valid
- o_load_data, o_alu_result  out  NB_DATA  extended load data; passed-through ALU result
- o_rd_addr  out  NB_REG;  o_ctrl_wb_bus  out  NB_CTRL_WB
- o_pc_src  out  1  branch taken
- o_misaligned  out  1  misaligned access flagged (with the macro defined)

## Operation
- FSM states: IDLE, REQ. A memory op is i_valid & (MemRead | MemWrite).
- IDLE, non-memory op: latch the op. Next cycle: o_valid=1, o_pc_src = Branch & (BNEQ ? ~i_zero : i_zero), o_load_data=0.
- IDLE, memory op: latch address, controls, store data and rd; go to REQ; o_valid=0 next cycle.
- REQ: o_mem_req=1, and address, be, we and wdata stay stable until i_mem_ready=1. On ready: capture and extract rdata, set o_valid=1 next cycle, return to IDLE.
- o_stall = (IDLE & i_valid & memop) | (REQ & ~i_mem_ready).
- Loads: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; otherwise the full word. Sign-extend unless Unsigned.
- Store byte enables: SB be = 1<<addr[1:0], wdata = {4{data[7:0]}}; SH be = addr[1]?1100:0011, wdata = {2{data[15:0]}}; SW be = 1111.
- MemRead and MemWrite both set: treated as a write.
- i_valid=0 in IDLE: o_valid=0 next cycle; all other outputs hold.

## Timing
- Reset: state IDLE; all outputs 0. Reset during REQ abandons the transaction, and o_mem_req is 0 after that edge.
- Non-memory op: 1-cycle latency, no stall.
- Memory op accepted at cycle N: o_mem_req is high from N+1. If i_mem_ready first rises at cycle M, o_valid is high at M+1. Zero-wait memory gives o_valid at N+2 and o_stall high only during cycle N.
- i_mem_ready outside REQ is ignored.
- o_valid is a single-cycle pulse per instruction.

## Configuration
- MEM_ACCESS_MISALIGN_TRAP_EN defined: a halfword with addr[0]=1 or a word with addr[1:0]≠0 issues no memory request. The next cycle gives o_valid=1, o_misaligned=1, o_ctrl_wb_bus=0, and there is no stall.
- Undefined: o_misaligned is tied to 0; low address bits are ignored (half aligns down to addr[1], word to addr[1:0]=0).

## Structure
- Shared package: bit-index constants of the mem/wb buses (SB_BIT…MEMWRITE_BIT, REGWRITE_BIT, MEMTOREG_BIT) and the state encoding, shared with the control unit.
- One sub-module, mem_lane_align: combinational byte-enable/wdata generation and load extraction/extension.

## Test plan
- Control 000000001 (SW), addr 0x10, data 0xDEADBEEF, ready after 2 wait cycles -> o_mem_be 1111, o_mem_addr 0x10, o_stall high 3 cycles, o_valid 1 cycle after ready.
- LB at addr 0x13, rdata 0x80FF_0000 -> o_load_data 0xFFFF_FF80. LBU (Unsigned=1) on the same inputs -> 0x0000_0080.
- SH, addr 0x22, data 0x1234ABCD -> be 1100, wdata 0xABCDABCD.
- BNE (000001100), i_zero=0 -> o_pc_src=1 one cycle later with no mem_req. BEQ (Branch only), i_zero=0 -> o_pc_src=0.
- i_rst low during REQ with i_mem_ready=0 -> after that edge o_mem_req=0, o_stall=0, o_valid=0, state IDLE.
- With the macro defined: LW at 0x06 -> o_mem_req never asserts; o_misaligned=1, o_ctrl_wb_bus=00. Without the macro -> o_mem_addr 0x04, normal load.
